// File: rtl/decode_stage.sv
// decode_stage
//   Registered RV32 decode stage sitting between fetch and execute. The
//   incoming instruction is decoded combinationally and the resulting bundle
//   is written into a 2-entry skid buffer. Entry 0 drives the outputs.
//   Entry 1 catches a bundle that arrives while entry 0 is stalled, so
//   in_ready can come straight from a flop.
//
//   Optional feature macro: DECODE_RVM_EN
//     When defined, OP with fn7=0000001 (the M extension) is legal.
//     When it is not defined, that encoding is flagged illegal.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   flush              synchronous kill of both skid entries
//   in_valid/in_ready  fetch-side handshake; in_instr, in_pc
//   out_valid/out_ready execute-side handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_fn3,
//   out_fn7_5, out_fn7_1, out_imm, out_rd_we, out_illegal   decoded bundle
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_fn3,
    output logic            out_fn7_5,
    output logic            out_fn7_1,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      fn3;
        logic            fn7_5;
        logic            fn7_1;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            illegal;
    } bundle_t;

    bundle_t     dec;
    logic [6:0]  opc;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic [31:0] imm32;
    logic        use_rd, use_rs1, use_rs2, use_fn3, use_fn7_5, use_fn7_1, ill;

    always_comb begin
        opc       = in_instr[6:0];
        fn3       = in_instr[14:12];
        fn7       = in_instr[31:25];
        imm32     = '0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_fn3   = 1'b1;
        use_fn7_5 = 1'b0;
        use_fn7_1 = 1'b0;
        ill       = 1'b0;
        case (opc)
            OPC_OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                if (fn3 == 3'b001) begin
                    use_fn7_5 = 1'b1;
                    ill       = (fn7 != 7'b0000000);
                end else if (fn3 == 3'b101) begin
                    use_fn7_5 = 1'b1;
                    ill       = (fn7 != 7'b0000000) && (fn7 != 7'b0100000);
                end
            end
            OPC_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                ill     = (fn3 == 3'b011) || (fn3 == 3'b110) || (fn3 == 3'b111);
            end
            OPC_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                ill     = (fn3 != 3'b000);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                ill     = (fn3 >= 3'b011);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
                ill     = (fn3 == 3'b010) || (fn3 == 3'b011);
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd  = 1'b1;
                use_fn3 = 1'b0;
                imm32   = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                use_rd  = 1'b1;
                use_fn3 = 1'b0;
                imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            end
            OPC_OP: begin
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                use_fn7_5 = 1'b1;
                use_fn7_1 = 1'b1;
                if (fn7 == 7'b0000000)
                    ill = 1'b0;
                else if (fn7 == 7'b0100000)
                    ill = (fn3 != 3'b000) && (fn3 != 3'b101);
`ifdef DECODE_RVM_EN
                else if (fn7 == 7'b0000001)
                    ill = 1'b0;
`endif
                else
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11)
            ill = 1'b1;

        // An illegal bundle carries only its PC and opcode so that execute
        // never sees stray register indices or write enables.
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = opc;
        dec.illegal = ill;
        if (!ill) begin
            dec.rd    = use_rd    ? in_instr[11:7]  : 5'd0;
            dec.rs1   = use_rs1   ? in_instr[19:15] : 5'd0;
            dec.rs2   = use_rs2   ? in_instr[24:20] : 5'd0;
            dec.fn3   = use_fn3   ? fn3             : 3'd0;
            dec.fn7_5 = use_fn7_5 & in_instr[30];
            dec.fn7_1 = use_fn7_1 & in_instr[25];
            dec.imm   = XLEN'(signed'(imm32));
            dec.rd_we = use_rd && (in_instr[11:7] != 5'd0);
        end
    end

    bundle_t e0_q, e0_d, e1_q, e1_d;
    logic    e0_valid_q, e0_valid_d, e1_valid_q, e1_valid_d;
    logic    push, pop;

    assign push = in_valid && !e1_valid_q;
    assign pop  = e0_valid_q && out_ready;

    always_comb begin
        e0_d       = e0_q;
        e1_d       = e1_q;
        e0_valid_d = e0_valid_q;
        e1_valid_d = e1_valid_q;
        if (flush) begin
            e0_valid_d = 1'b0;
            e1_valid_d = 1'b0;
        end else if (e1_valid_q) begin
            // Full: no push is possible because in_ready is low.
            if (pop) begin
                e0_d       = e1_q;
                e1_valid_d = 1'b0;
            end
        end else if (e0_valid_q) begin
            if (push && pop) begin
                e0_d = dec;
            end else if (pop) begin
                e0_valid_d = 1'b0;
            end else if (push) begin
                e1_d       = dec;
                e1_valid_d = 1'b1;
            end
        end else if (push) begin
            e0_d       = dec;
            e0_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q       <= '0;
            e1_q       <= '0;
            e0_valid_q <= 1'b0;
            e1_valid_q <= 1'b0;
        end else begin
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            e0_valid_q <= e0_valid_d;
            e1_valid_q <= e1_valid_d;
        end
    end

    assign in_ready    = !e1_valid_q;
    assign out_valid   = e0_valid_q;
    assign out_pc      = e0_q.pc;
    assign out_opcode  = e0_q.opcode;
    assign out_rd      = e0_q.rd;
    assign out_rs1     = e0_q.rs1;
    assign out_rs2     = e0_q.rs2;
    assign out_fn3     = e0_q.fn3;
    assign out_fn7_5   = e0_q.fn7_5;
    assign out_fn7_1   = e0_q.fn7_1;
    assign out_imm     = e0_q.imm;
    assign out_rd_we   = e0_q.rd_we;
    assign out_illegal = e0_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed bench for decode_stage: a table of single-instruction vectors
//   with hand-computed decode results, followed by hand-written sequences
//   for async reset, back-pressure, flush and sustained throughput.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_fn3;
    logic        out_fn7_5, out_fn7_1;
    logic [31:0] out_imm;
    logic        out_rd_we, out_illegal;

    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_fn3(out_fn3), .out_fn7_5(out_fn7_5), .out_fn7_1(out_fn7_1),
        .out_imm(out_imm), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fn3;
        logic        fn7_5;
        logic        fn7_1;
        logic [31:0] imm;
        logic        rd_we;
        logic        illegal;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    int n_applied = 0;
    int n_err     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [31:0] seq_instr [4];
    logic [31:0] got_pc [4];
    int          idx, got;
    logic        rdy;

    initial begin
        //           instr         opc       rd     rs1    rs2    fn3   f5    f1    imm           we    ill
        vec[0]  = '{32'hFFF08293, 7'h13, 5'd5,  5'd1, 5'd0, 3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0}; // addi x5,x1,-1
        vec[1]  = '{32'hFE208EE3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0}; // beq x1,x2,-4
        vec[2]  = '{32'h0080006F, 7'h6F, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0}; // jal x0,+8
`ifdef DECODE_RVM_EN
        vec[3]  = '{32'h022081B3, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0}; // mul
`else
        vec[3]  = '{32'h022081B3, 7'h33, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // mul
`endif
        vec[4]  = '{32'h002081B3, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0}; // add
        vec[5]  = '{32'h402081B3, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0}; // sub
        vec[6]  = '{32'h123453B7, 7'h37, 5'd7,  5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h12345000, 1'b1, 1'b0}; // lui
        vec[7]  = '{32'hFE20AC23, 7'h23, 5'd0,  5'd1, 5'd2, 3'd2, 1'b0, 1'b0, 32'hFFFFFFF8, 1'b0, 1'b0}; // sw x2,-8(x1)
        vec[8]  = '{32'h40325213, 7'h13, 5'd4,  5'd4, 5'd0, 3'd5, 1'b1, 1'b0, 32'h00000403, 1'b1, 1'b0}; // srai x4,x4,3
        vec[9]  = '{32'h40321213, 7'h13, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // slli bad fn7
        vec[10] = '{32'h00000001, 7'h01, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // [1:0]!=11
        vec[11] = '{32'h00009067, 7'h67, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // jalr fn3=1
        vec[12] = '{32'h00000013, 7'h13, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0}; // nop
        vec[13] = '{32'h7FF12503, 7'h03, 5'd10, 5'd2, 5'd0, 3'd2, 1'b0, 1'b0, 32'h000007FF, 1'b1, 1'b0}; // lw x10,2047(x2)
        vec[14] = '{32'h80000097, 7'h17, 5'd1,  5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0}; // auipc
        vec[15] = '{32'h0020A063, 7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // branch fn3=2

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_imm", out_imm, 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-instruction decode table
        for (int i = 0; i < NV; i++) begin
            in_instr = vec[i].instr;
            in_pc    = 32'h1000 + 32'(i * 4);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d_opcode", i), 32'(out_opcode), 32'(vec[i].opcode));
            chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vec[i].rd));
            chk($sformatf("v%0d_rs1", i), 32'(out_rs1), 32'(vec[i].rs1));
            chk($sformatf("v%0d_rs2", i), 32'(out_rs2), 32'(vec[i].rs2));
            chk($sformatf("v%0d_fn3", i), 32'(out_fn3), 32'(vec[i].fn3));
            chk($sformatf("v%0d_fn7_5", i), 32'(out_fn7_5), 32'(vec[i].fn7_5));
            chk($sformatf("v%0d_fn7_1", i), 32'(out_fn7_1), 32'(vec[i].fn7_1));
            chk($sformatf("v%0d_imm", i), out_imm, vec[i].imm);
            chk($sformatf("v%0d_rd_we", i), 32'(out_rd_we), 32'(vec[i].rd_we));
            chk($sformatf("v%0d_illegal", i), 32'(out_illegal), 32'(vec[i].illegal));
            @(negedge clk);
            chk($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Back-pressure: 4 instructions, out_ready low for 3 cycles
        seq_instr[0] = 32'h00100093; seq_instr[1] = 32'h00200113;
        seq_instr[2] = 32'h00300193; seq_instr[3] = 32'h00400213;
        idx = 0; got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_instr = seq_instr[idx];
            in_pc    = 32'h2000 + 32'(idx * 4);
            rdy      = in_ready;
            @(posedge clk);
            if (rdy) idx++;
            @(negedge clk);
        end
        chk("bp_accepted_before_stall", 32'(idx), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_head_pc_held", out_pc, 32'h2000);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (out_valid) begin
                got_pc[got] = out_pc;
                got++;
            end
            in_valid = (idx < 4);
            if (idx < 4) begin
                in_instr = seq_instr[idx];
                in_pc    = 32'h2000 + 32'(idx * 4);
            end
            rdy = in_ready;
            @(posedge clk);
            if (rdy && in_valid) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_received_count", 32'(got), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_order_%0d", k), (k < got) ? got_pc[k] : 32'hDEAD, 32'h2000 + 32'(k * 4));
        chk("bp_empty_after", 32'(out_valid), 32'd0);

        // Flush with both entries full and in_valid asserted
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = seq_instr[0]; in_pc = 32'h3000;
        @(negedge clk);
        in_instr = seq_instr[1]; in_pc = 32'h3004;
        @(negedge clk);
        chk("fl_full_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; in_instr = seq_instr[2]; in_pc = 32'h3008;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        // Flush with one entry and an acceptable push in the same cycle
        in_valid = 1'b1; in_instr = seq_instr[0]; in_pc = 32'h3010;
        @(negedge clk);
        flush = 1'b1; in_instr = seq_instr[1]; in_pc = 32'h3014;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = seq_instr[3]; in_pc = 32'h3020;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl_post_valid", 32'(out_valid), 32'd1);
        chk("fl_post_pc", out_pc, 32'h3020);
        @(negedge clk);
        chk("fl_post_drained", 32'(out_valid), 32'd0);

        // Sustained throughput: one instruction per cycle with out_ready high
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                chk($sformatf("tp_valid_%0d", k), 32'(out_valid), 32'd1);
                chk($sformatf("tp_pc_%0d", k), out_pc, 32'h4000 + 32'((k - 1) * 4));
                chk($sformatf("tp_ready_%0d", k), 32'(in_ready), 32'd1);
            end
            in_valid = (k < 4);
            in_instr = seq_instr[k % 4];
            in_pc    = 32'h4000 + 32'(k * 4);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Async reset mid-stream with a bundle held
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF08293; in_pc = 32'h5000;
        @(negedge clk);
        in_instr = 32'h0080006F; in_pc = 32'h5004;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_pre_imm", out_imm, 32'hFFFFFFFF);
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_out_imm", out_imm, 32'd0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("ar_stays_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
